muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width in bits (legal range 8..64).
REQ-002 The block SHALL have parameter MUL_LAT, default 5, giving the busy cycles of a multiply (legal range 1..31).
REQ-003 The block SHALL have parameter DIV_LAT, default 10, giving the busy cycles of a divide (legal range 1..31).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: request to issue op this cycle.
REQ-007 The block SHALL have port op, input, 3 bits: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are reserved.
REQ-008 The block SHALL have ports a and b, input, WIDTH bits each: operand 1 (rs) and operand 2 (rt).
REQ-009 The block SHALL have port cancel, input, 1 bit: abort any in-flight operation (pipeline flush).
REQ-010 The block SHALL have port busy, output, 1 bit: an operation is in flight.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse in the cycle HI/LO take a result.
REQ-012 The block SHALL have ports hi and lo, output, WIDTH bits each: the current HI and LO registers (MFHI/MFLO source).

Function
REQ-013 The block SHALL accept start only when busy=0 and cancel=0; start while busy=1 SHALL be ignored with no state change.
REQ-014 An accepted MTHI SHALL write hi<=a, and an accepted MTLO SHALL write lo<=a, at the same edge; busy stays 0 and done is not pulsed.
REQ-015 An accepted MULT/MULTU/DIV/DIVU SHALL latch a, b and op, load the counter with MUL_LAT or DIV_LAT, and assert busy from the next cycle.
REQ-016 busy SHALL be high for exactly LAT consecutive cycles.
REQ-017 HI/LO SHALL update at the edge ending the last busy cycle, and done SHALL be high for the cycle after that edge.
REQ-018 The block SHALL use a two-state FSM, IDLE and RUN; RUN returns to IDLE when the counter reaches 1 or on cancel.
REQ-019 MULT SHALL compute the signed 2*WIDTH-bit product and MULTU the unsigned product, with hi = upper WIDTH bits and lo = lower WIDTH bits.
REQ-020 DIV SHALL compute signed division truncating toward zero, with lo = quotient and hi = remainder, the remainder taking the sign of the dividend; DIVU SHALL compute the unsigned equivalent.
REQ-021 Signed overflow (a = most-negative, b = -1) SHALL give lo = most-negative and hi = 0.
REQ-022 Divide by zero (b=0) SHALL run the full DIV_LAT, leave hi/lo unchanged and still pulse done.
REQ-023 cancel=1 while busy SHALL return the block to IDLE at the next edge, leave hi/lo unchanged and produce no done pulse.
REQ-024 cancel=1 in the same cycle as start SHALL suppress the start.
REQ-025 cancel=1 while idle SHALL have no effect.
REQ-026 A new start SHALL be accepted in the cycle in which done is high, allowing back-to-back operations.
REQ-027 Reserved op codes SHALL be ignored.
REQ-028 Results SHALL be independent of changes to a/b after acceptance.

Reset
REQ-029 While reset=0, the block SHALL hold hi=0, lo=0, busy=0, done=0, state IDLE and counter 0, regardless of clk.
REQ-030 Reset asserted mid-operation SHALL discard the operation with no done pulse.
REQ-031 Deassertion of reset SHALL be synchronised by the user; the first edge after release may accept start.

Structure
REQ-032 The op encodings, the FSM state type and the default latencies SHALL be placed in shared package mips_pkg.
REQ-033 The datapath MAY be built as one sub-module, muldiv_core (combinational or iterative), instantiated once; the counter, FSM and HI/LO SHALL be in muldiv_unit.

Verification
REQ-034 Reset release, then MULT a=0xFFFFFFFE (-2), b=3 -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done for 1 cycle.
REQ-035 DIV a=0xFFFFFFF9 (-7), b=2 -> after 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1.
REQ-036 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU a=5, b=0 -> hi/lo unchanged, done pulses.
REQ-037 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, cancel on the 3rd busy cycle -> busy=0 at the next cycle, hi/lo keep their prior values, no done.
REQ-038 MTHI a=0x12345678, then a start issued while a MULT is busy -> hi=0x12345678 next cycle, and the second start is ignored (its result never appears).
REQ-039 Parameter sweep WIDTH=16, MUL_LAT=1, DIV_LAT=3 with random operands against a reference model -> hi/lo match and the busy length is exact.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: op encodings, FSM state type and default latencies shared by the multiply/divide unit
package mips_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef logic [0:0] state_t;
    localparam state_t S_IDLE = 1'b0;
    localparam state_t S_RUN  = 1'b1;

    localparam int DEF_MUL_LAT = 5;
    localparam int DEF_DIV_LAT = 10;

endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: combinational multiply/divide datapath; kind[1] selects divide, kind[0] selects unsigned
module muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       kind,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             wr
);

    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2*WIDTH-1:0] ax, bx, prod;
    logic signed [WIDTH-1:0] sa, sb;
    logic [WIDTH-1:0] qs, rs, qu, ru;
    logic ovf;

    // Sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits of the product are then correct for both
    assign ax   = kind[0] ? {{WIDTH{1'b0}}, a} : {{WIDTH{a[WIDTH-1]}}, a};
    assign bx   = kind[0] ? {{WIDTH{1'b0}}, b} : {{WIDTH{b[WIDTH-1]}}, b};
    assign prod = ax * bx;

    assign sa = a;
    assign sb = b;
    assign qs = sa / sb;
    assign rs = sa % sb;
    assign qu = a / b;
    assign ru = a % b;

    // most-negative / -1 cannot be represented, so it is pinned explicitly
    assign ovf = !kind[0] && a == MIN && b == '1;

    assign wr = kind[1] ? (b != '0) : 1'b1;
    assign hi = kind[1] ? (kind[0] ? ru : (ovf ? '0 : rs)) : prod[2*WIDTH-1:WIDTH];
    assign lo = kind[1] ? (kind[0] ? qu : (ovf ? MIN : qs)) : prod[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: MIPS-style HI/LO multiply/divide unit with fixed busy latency and cancel
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t state;
    logic [4:0] cnt;
    logic [1:0] kind;
    logic [WIDTH-1:0] a_q, b_q, res_hi, res_lo;
    logic wr, go, last;

    assign busy = state == S_RUN;
    assign go   = start && !cancel && !busy;
    assign last = busy && !cancel && cnt == 5'd1;

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .kind(kind),
        .a   (a_q),
        .b   (b_q),
        .hi  (res_hi),
        .lo  (res_lo),
        .wr  (wr)
    );

    // Accept ops, count the busy window down and commit the result to HI/LO on the last busy edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            kind  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= last;
            if (go && op == OP_MTHI) hi <= a;
            if (go && op == OP_MTLO) lo <= a;
            if (go && !op[2]) begin
                state <= S_RUN;
                kind  <= op[1:0];
                a_q   <= a;
                b_q   <= b;
                cnt   <= op[1] ? 5'(DIV_LAT) : 5'(MUL_LAT);
            end
            if (busy) begin
                state <= (cancel || cnt == 5'd1) ? S_IDLE : S_RUN;
                cnt   <= (cancel || cnt == 5'd1) ? 5'd0 : cnt - 5'd1;
            end
            if (last && wr) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit (32-bit default and 16-bit sweep) against a behavioural model
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        start [2];
    logic [2:0]  op    [2];
    logic [31:0] a     [2];
    logic [31:0] b     [2];
    logic        cancel[2];
    logic        busy_o[2];
    logic        done_o[2];
    logic [31:0] hi_o  [2];
    logic [31:0] lo_o  [2];

    int tests = 0;
    int fails = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Plain wide-integer arithmetic: result {hi, lo} of a w-bit operation, ok=0 for divide by zero
    function automatic logic [63:0] ref_res(int w, logic [2:0] o, logic [31:0] x, logic [31:0] y, output bit ok);
        logic [63:0] mask = (64'd1 << w) - 64'd1;
        logic [63:0] ux = {32'd0, x} & mask;
        logic [63:0] uy = {32'd0, y} & mask;
        longint sx = ux[w-1] ? longint'(ux) - longint'(64'd1 << w) : longint'(ux);
        longint sy = uy[w-1] ? longint'(uy) - longint'(64'd1 << w) : longint'(uy);
        logic [63:0] p = 0, hv = 0, lv = 0;
        ok = 1;
        case (o)
            3'd0: begin p = sx * sy; hv = p >> w; lv = p; end
            3'd1: begin p = ux * uy; hv = p >> w; lv = p; end
            3'd2: begin ok = uy != 0; if (ok) begin lv = sx / sy; hv = sx % sy; end end
            default: begin ok = uy != 0; if (ok) begin lv = ux / uy; hv = ux % uy; end end
        endcase
        return {hv[31:0] & mask[31:0], lv[31:0] & mask[31:0]};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int W  = g == 0 ? 32 : 16;
        localparam int ML = g == 0 ? 5 : 1;
        localparam int DL = g == 0 ? 10 : 3;
        logic [W-1:0] h, l;
        logic bz, dn;

        muldiv_unit #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
            .clk   (clk),
            .reset (reset),
            .start (start[g]),
            .op    (op[g]),
            .a     (a[g][W-1:0]),
            .b     (b[g][W-1:0]),
            .cancel(cancel[g]),
            .busy  (bz),
            .done  (dn),
            .hi    (h),
            .lo    (l)
        );
        assign busy_o[g] = bz;
        assign done_o[g] = dn;
        assign hi_o[g]   = 32'(h);
        assign lo_o[g]   = 32'(l);

        // Model: an accepted mul/div holds a precomputed result that lands LAT edges later unless cancelled
        logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
        bit m_busy = 0, m_done = 0, p_ok = 0;
        int cyc = 0, end_cyc = 0;
        always @(posedge clk or negedge reset) begin
            if (!reset) begin
                m_hi = 0; m_lo = 0; m_busy = 0; m_done = 0;
            end else begin
                cyc++;
                m_done = 0;
                if (m_busy) begin
                    if (cancel[g]) m_busy = 0;
                    else if (cyc == end_cyc) begin
                        m_busy = 0;
                        m_done = 1;
                        if (p_ok) begin m_hi = p_hi; m_lo = p_lo; end
                    end
                end else if (start[g] && !cancel[g]) begin
                    if (op[g] == 3'd4) m_hi = 32'(a[g][W-1:0]);
                    else if (op[g] == 3'd5) m_lo = 32'(a[g][W-1:0]);
                    else if (op[g] < 3'd4) begin
                        {p_hi, p_lo} = ref_res(W, op[g], a[g], b[g], p_ok);
                        m_busy = 1;
                        end_cyc = cyc + (op[g][1] ? DL : ML);
                    end
                end
            end
        end

        // Compare every cycle, away from the active edge
        always @(negedge clk) begin
            chk($sformatf("u%0d.busy", g), busy_o[g], m_busy);
            chk($sformatf("u%0d.done", g), done_o[g], m_done);
            chk($sformatf("u%0d.hi", g), hi_o[g], m_hi);
            chk($sformatf("u%0d.lo", g), lo_o[g], m_lo);
        end
    end

    task automatic issue(int k, logic [2:0] o, logic [31:0] x, logic [31:0] y);
        start[k] = 1'b1; op[k] = o; a[k] = x; b[k] = y;
        @(negedge clk);
        start[k] = 1'b0; a[k] = $urandom; b[k] = $urandom;
    endtask

    task automatic wait_done(int k, int lat, string name);
        int n = 0;
        while (busy_o[k] && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk({name, " busy cycles"}, n, lat);
        chk({name, " done"}, done_o[k], 1);
    endtask

    task automatic hl(string name, logic [31:0] eh, logic [31:0] el);
        chk({name, " hi"}, hi_o[0], eh);
        chk({name, " lo"}, lo_o[0], el);
    endtask

    function automatic logic [31:0] rnd(int w);
        case ($urandom_range(0, 5))
            0: return 0;
            1: return 1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1 << (w - 1);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            start[k] = 0; op[k] = 0; a[k] = 0; b[k] = 0; cancel[k] = 0;
        end
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy_o[0], 0);
        chk("reset done", done_o[0], 0);
        hl("reset", 0, 0);
        reset = 1'b1;
        @(negedge clk);

        issue(0, 3'd0, 32'hFFFF_FFFE, 32'd3);
        wait_done(0, 5, "mult");
        hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        issue(0, 3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done(0, 10, "div");
        hl("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(0, 3'd3, 32'd7, 32'd2);
        wait_done(0, 10, "divu");
        hl("divu", 32'd1, 32'd3);
        issue(0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0, 10, "div ovf");
        hl("div ovf", 32'd0, 32'h8000_0000);
        issue(0, 3'd3, 32'd5, 32'd0);
        wait_done(0, 10, "divu0");
        hl("divu0", 32'd0, 32'h8000_0000);
        @(negedge clk);
        chk("done width", done_o[0], 0);

        issue(0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        @(negedge clk);
        cancel[0] = 1'b1;
        @(negedge clk);
        cancel[0] = 1'b0;
        chk("cancel busy", busy_o[0], 0);
        for (int i = 0; i < 8; i++) begin
            chk("cancel no done", done_o[0], 0);
            @(negedge clk);
        end
        hl("cancel", 32'd0, 32'h8000_0000);

        issue(0, 3'd4, 32'h1234_5678, 32'd0);
        chk("mthi busy", busy_o[0], 0);
        hl("mthi", 32'h1234_5678, 32'h8000_0000);
        issue(0, 3'd5, 32'hCAFE_F00D, 32'd0);
        hl("mtlo", 32'h1234_5678, 32'hCAFE_F00D);

        issue(0, 3'd0, 32'd2, 32'd3);
        issue(0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(0, 4, "mult ignore");
        hl("mult ignore", 32'd0, 32'd6);
        @(negedge clk);
        chk("ignored start", busy_o[0], 0);

        issue(0, 3'd6, 32'd9, 32'd9);
        chk("reserved6", busy_o[0], 0);
        issue(0, 3'd7, 32'd9, 32'd9);
        chk("reserved7", busy_o[0], 0);
        hl("reserved", 32'd0, 32'd6);
        cancel[0] = 1'b1;
        issue(0, 3'd0, 32'd5, 32'd5);
        cancel[0] = 1'b0;
        chk("cancel+start", busy_o[0], 0);

        issue(0, 3'd2, 32'd100, 32'd7);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async reset busy", busy_o[0], 0);
        hl("async reset", 0, 0);
        @(negedge clk);
        chk("async reset done", done_o[0], 0);
        reset = 1'b1;
        @(negedge clk);

        repeat (4000) begin
            for (int k = 0; k < 2; k++) begin
                start[k]  = $urandom_range(0, 2) == 0;
                op[k]     = 3'($urandom_range(0, 7));
                a[k]      = rnd(k == 0 ? 32 : 16);
                b[k]      = rnd(k == 0 ? 32 : 16);
                cancel[k] = $urandom_range(0, 24) == 0;
            end
            @(negedge clk);
        end
        for (int k = 0; k < 2; k++) begin
            start[k] = 0; cancel[k] = 0;
        end
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
